gated_bus_mux: RTL and testbench

Parametrised, registered replacement for the point-to-point datapath selectors and the shared internal bus of the LC-3 processor. It selects one of `NSRC` gated sources onto a `WIDTH`-bit bus using one-hot gate enables. It holds the last driven value when no gate is active, and provides a registered bus copy with a valid flag. With checking compiled in, it also detects multi-gate conflicts using a sticky flag, a saturating counter and capture of the offending gate vector. It sits between the datapath sources (PC, MDR, ALU, MARMUX) and the consumers (IR, MAR, MDR, register file, PC).

---
 rtl/lc3_bus_pkg.sv | 25 ++
 rtl/bus_prio_enc.sv | 25 ++
 rtl/gated_bus_mux.sv | 103 ++++++++++
 tb/tb_gated_bus_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_bus_pkg.sv
// Shared constants for the LC-3 gated internal bus: width, source indices and
// conflict counter sizing.
package lc3_bus_pkg;

  localparam int unsigned BUS_WIDTH      = 16;
  localparam int unsigned GATE_PC        = 0;
  localparam int unsigned GATE_MDR       = 1;
  localparam int unsigned GATE_ALU       = 2;
  localparam int unsigned GATE_MARMUX    = 3;
  localparam int unsigned CONFLICT_CNT_W = 8;

  localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

  typedef enum logic [1:0] {
    GatePc     = 2'(GATE_PC),
    GateMdr    = 2'(GATE_MDR),
    GateAlu    = 2'(GATE_ALU),
    GateMarmux = 2'(GATE_MARMUX)
  } lc3_gate_e;

  function automatic logic [CONFLICT_CNT_W-1:0] sat_inc(input logic [CONFLICT_CNT_W-1:0] v);
    return (v == CONFLICT_CNT_MAX) ? v : v + CONFLICT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Lowest-index-wins priority encoder over the gate enables, with flags for an
// empty and a multi-hot gate vector.
module bus_prio_enc #(
  parameter int unsigned NSRC = 4,
  localparam int unsigned IdxW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] gate_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o,
  output logic            multi_o
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (gate_i[i]) idx_o = IdxW'(i);
    end
  end

  assign any_o   = |gate_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(gate_i & (gate_i - NSRC'(1)));

endmodule

// File: rtl/gated_bus_mux.sv
// Registered gated bus selector with last-value hold and optional multi-gate
// conflict checking (enabled by defining GATED_BUS_CONFLICT_CHECK_EN).
module gated_bus_mux
  import lc3_bus_pkg::*;
#(
  parameter int unsigned WIDTH = BUS_WIDTH,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned HOLD  = 1,
  localparam int unsigned IdxW = $clog2(NSRC)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NSRC-1:0]           gate,
  input  logic [NSRC*WIDTH-1:0]     src_data,
  input  logic                      clear_err,
  output logic [WIDTH-1:0]          bus,
  output logic [WIDTH-1:0]          bus_q,
  output logic                      bus_valid,
  output logic                      conflict,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt,
  output logic [NSRC-1:0]           conflict_gate
);

  logic [IdxW-1:0]  win_idx;
  logic             any_gate;
  logic             multi_gate;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] held_q, held_d;

  bus_prio_enc #(
    .NSRC(NSRC)
  ) u_prio_enc (
    .gate_i (gate),
    .idx_o  (win_idx),
    .any_o  (any_gate),
    .multi_o(multi_gate)
  );

  assign sel_data = src_data[win_idx*WIDTH +: WIDTH];

  always_comb begin
    held_d = held_q;
    bus    = (HOLD != 0) ? held_q : '0;
    if (any_gate) begin
      held_d = sel_data;
      bus    = sel_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      held_q    <= '0;
      bus_q     <= '0;
      bus_valid <= 1'b0;
    end else begin
      held_q    <= held_d;
      bus_q     <= bus;
      bus_valid <= any_gate;
    end
  end

`ifdef GATED_BUS_CONFLICT_CHECK_EN
  logic                      conflict_d;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_d;
  logic [NSRC-1:0]           conflict_gate_d;

  // A conflict in the clear cycle restarts the status rather than being lost.
  always_comb begin
    conflict_d      = conflict;
    conflict_cnt_d  = conflict_cnt;
    conflict_gate_d = conflict_gate;
    if (clear_err) begin
      conflict_d      = multi_gate;
      conflict_cnt_d  = multi_gate ? CONFLICT_CNT_W'(1) : '0;
      conflict_gate_d = multi_gate ? gate : '0;
    end else if (multi_gate) begin
      conflict_d     = 1'b1;
      conflict_cnt_d = sat_inc(conflict_cnt);
      if (!conflict) conflict_gate_d = gate;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      conflict      <= 1'b0;
      conflict_cnt  <= '0;
      conflict_gate <= '0;
    end else begin
      conflict      <= conflict_d;
      conflict_cnt  <= conflict_cnt_d;
      conflict_gate <= conflict_gate_d;
    end
  end
`else
  logic unused_check_inputs;
  assign unused_check_inputs = clear_err ^ multi_gate;

  assign conflict      = 1'b0;
  assign conflict_cnt  = '0;
  assign conflict_gate = '0;
`endif

endmodule

// File: tb/tb_gated_bus_mux.sv
// Bench for gated_bus_mux: directed vector table, saturation run and random
// stimulus checked against a behavioural model.
module tb_gated_bus_mux;

`ifdef GATED_BUS_CONFLICT_CHECK_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [3:0]  gate;
  logic [63:0] src;
  logic [15:0] bus, bus_q, bus0, bus0_q;
  logic        bus_valid, conflict, bus0_valid, conflict0;
  logic [7:0]  cnt, cnt0;
  logic [3:0]  cgate, cgate0;

  always #5 clk = ~clk;

  gated_bus_mux #(.WIDTH(16), .NSRC(4), .HOLD(1)) dut (
    .Clk(clk), .Reset(rst), .gate(gate), .src_data(src), .clear_err(clr),
    .bus(bus), .bus_q(bus_q), .bus_valid(bus_valid), .conflict(conflict),
    .conflict_cnt(cnt), .conflict_gate(cgate)
  );

  gated_bus_mux #(.WIDTH(16), .NSRC(4), .HOLD(0)) dut0 (
    .Clk(clk), .Reset(rst), .gate(gate), .src_data(src), .clear_err(clr),
    .bus(bus0), .bus_q(bus0_q), .bus_valid(bus0_valid), .conflict(conflict0),
    .conflict_cnt(cnt0), .conflict_gate(cgate0)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [15:0] m_held, m_bq, m_bq0;
  logic        m_v, m_cf;
  int          m_cnt;
  logic [3:0]  m_cg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic int lowest(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] model_bus(input logic [3:0] g, input logic [63:0] s,
                                            input bit hold);
    int w = lowest(g);
    if (w >= 0) return s[w*16 +: 16];
    return hold ? m_held : 16'h0;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [3:0] g,
                            input logic [63:0] s);
    int w = lowest(g);
    logic [15:0] b = model_bus(g, s, 1'b1);
    logic [15:0] b0 = model_bus(g, s, 1'b0);
    bit multi = $countones(g) > 1;
    if (r) begin
      m_held = 0; m_bq = 0; m_bq0 = 0; m_v = 0; m_cf = 0; m_cnt = 0; m_cg = 0;
    end else begin
      m_bq = b;
      m_bq0 = b0;
      m_v = (w >= 0);
      if (w >= 0) m_held = s[w*16 +: 16];
      if (CE) begin
        if (c) begin
          m_cf = multi; m_cnt = multi ? 1 : 0; m_cg = multi ? g : 4'h0;
        end else if (multi) begin
          if (!m_cf) m_cg = g;
          m_cf = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  // One clock: drive after negedge, sample bus before the edge, registers after it.
  task automatic cycle(input logic r, input logic c, input logic [3:0] g, input logic [63:0] s,
                       output logic [15:0] ob, output logic [15:0] ob0,
                       output logic [15:0] mb, output logic [15:0] mb0);
    @(negedge clk);
    rst = r; clr = c; gate = g; src = s;
    #1;
    ob = bus; ob0 = bus0;
    mb = model_bus(g, s, 1'b1);
    mb0 = model_bus(g, s, 1'b0);
    @(posedge clk);
    model_step(r, c, g, s);
    #1;
  endtask

  function automatic logic [7:0] c8(input logic [7:0] v);
    return CE ? v : 8'h0;
  endfunction

  typedef struct {
    logic        r, c;
    logic [3:0]  g;
    logic [63:0] s;
    logic [15:0] e_bus, e_bus0, e_bq;
    logic        e_v, e_cf;
    logic [7:0]  e_cnt;
    logic [3:0]  e_cg;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic c, input logic [3:0] g,
                              input logic [63:0] s, input logic [15:0] eb,
                              input logic [15:0] eb0, input logic [15:0] ebq, input logic ev,
                              input logic ecf, input logic [7:0] ecnt, input logic [3:0] ecg);
    vec_t v;
    v.r = r; v.c = c; v.g = g; v.s = s; v.e_bus = eb; v.e_bus0 = eb0; v.e_bq = ebq;
    v.e_v = ev; v.e_cf = ecf; v.e_cnt = ecnt; v.e_cg = ecg;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    logic [15:0] ob, ob0, mb, mb0;
    logic [3:0]  g;
    logic        r, c;

    tbl[0] = mk(0, 0, 4'b0000, 64'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 4'h0);
    tbl[1] = mk(0, 0, 4'b0100, 64'h9999_1234_7777_6666, 16'h1234, 16'h1234, 16'h1234,
                1, 0, 0, 4'h0);
    tbl[2] = mk(0, 0, 4'b0000, 64'h9999_8888_7777_6666, 16'h1234, 16'h0, 16'h1234,
                0, 0, 0, 4'h0);
    tbl[3] = mk(0, 0, 4'b1010, 64'h5555_1111_AAAA_2222, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                1, CE, c8(1), CE ? 4'b1010 : 4'h0);
    tbl[4] = mk(0, 0, 4'b0011, 64'h5555_4444_2222_1111, 16'h1111, 16'h1111, 16'h1111,
                1, CE, c8(2), CE ? 4'b1010 : 4'h0);
    tbl[5] = mk(0, 1, 4'b0110, 64'h5555_4444_3333_1111, 16'h3333, 16'h3333, 16'h3333,
                1, CE, c8(1), CE ? 4'b0110 : 4'h0);
    tbl[6] = mk(0, 1, 4'b0000, 64'h5555_4444_2222_1111, 16'h3333, 16'h0, 16'h3333,
                0, 0, 0, 4'h0);
    tbl[7] = mk(1, 0, 4'b0001, 64'h5555_4444_2222_BEEF, 16'hBEEF, 16'hBEEF, 16'h0,
                0, 0, 0, 4'h0);
    tbl[8] = mk(0, 0, 4'b0000, 64'h5555_4444_2222_1111, 16'h0, 16'h0, 16'h0,
                0, 0, 0, 4'h0);

    rst = 1'b1; clr = 1'b0; gate = '0; src = '0;
    m_held = 0; m_bq = 0; m_bq0 = 0; m_v = 0; m_cf = 0; m_cnt = 0; m_cg = 0;
    cycle(1, 0, 4'h0, 64'h0, ob, ob0, mb, mb0);
    cycle(1, 0, 4'h0, 64'h0, ob, ob0, mb, mb0);

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].c, tbl[i].g, tbl[i].s, ob, ob0, mb, mb0);
      chk($sformatf("v%0d bus", i), 32'(ob), 32'(tbl[i].e_bus));
      chk($sformatf("v%0d bus_hold0", i), 32'(ob0), 32'(tbl[i].e_bus0));
      chk($sformatf("v%0d bus_q", i), 32'(bus_q), 32'(tbl[i].e_bq));
      chk($sformatf("v%0d bus_valid", i), 32'(bus_valid), 32'(tbl[i].e_v));
      chk($sformatf("v%0d conflict", i), 32'(conflict), 32'(tbl[i].e_cf));
      chk($sformatf("v%0d conflict_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d conflict_gate", i), 32'(cgate), 32'(tbl[i].e_cg));
    end

    for (int k = 1; k <= 300; k++) begin
      cycle(0, 0, 4'hF, {$urandom, $urandom}, ob, ob0, mb, mb0);
      if (k == 254) chk("sat cnt@254", 32'(cnt), 32'(c8(254)));
      if (k == 255) chk("sat cnt@255", 32'(cnt), 32'(c8(255)));
    end
    chk("sat cnt@300", 32'(cnt), 32'(c8(255)));
    chk("sat conflict", 32'(conflict), 32'(CE));
    chk("sat conflict_gate", 32'(cgate), CE ? 32'hF : 32'h0);
    cycle(0, 1, 4'h0, 64'h0, ob, ob0, mb, mb0);
    chk("clear cnt", 32'(cnt), 32'h0);
    chk("clear conflict", 32'(conflict), 32'h0);

    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       g = 4'h0;
        1:       g = 4'(1 << $urandom_range(0, 3));
        default: g = 4'($urandom);
      endcase
      cycle(r, c, g, {$urandom, $urandom}, ob, ob0, mb, mb0);
      chk($sformatf("r%0d bus", k), 32'(ob), 32'(mb));
      chk($sformatf("r%0d bus_hold0", k), 32'(ob0), 32'(mb0));
      chk($sformatf("r%0d bus_q", k), 32'(bus_q), 32'(m_bq));
      chk($sformatf("r%0d bus_q_hold0", k), 32'(bus0_q), 32'(m_bq0));
      chk($sformatf("r%0d bus_valid", k), 32'(bus_valid), 32'(m_v));
      chk($sformatf("r%0d conflict", k), 32'(conflict), 32'(m_cf));
      chk($sformatf("r%0d conflict_cnt", k), 32'(cnt), 32'(m_cnt));
      chk($sformatf("r%0d conflict_gate", k), 32'(cgate), 32'(m_cg));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
